// File: rtl/uart_ext_pkg.sv
// Shared types and helpers for the parametrised UART: parity encodings, FSM state
// enums and the oversample-tick divider calculation.
package uart_ext_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_t;

    function automatic int unsigned os_div(input int unsigned clk, input int unsigned baud,
                                           input int unsigned os);
        int unsigned d;
        d = clk / (baud * os);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_ext_fifo.sv
// Synchronous FIFO with registered flags and a registered show-ahead head output
// that reads as zero while the FIFO is empty.
module uart_ext_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;
    logic [DATA_WIDTH-1:0] head_d;

    always_comb begin
        do_pop   = read_en && !empty;
        // A push on a full FIFO is accepted only when a pop frees a slot in the same clock.
        do_push  = write_en && (!full || do_pop);
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (count_d == '0) begin
            head_d = '0;
        end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = data_in;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_out <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_out <= head_d;
            empty    <= (count_d == '0);
            full     <= (count_d == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_ext.sv
// Full-duplex UART with configurable width, parity and stop bits, 16x oversampled
// receiver with sticky error flags, and TX/RX FIFOs.
module uart_ext
    import uart_ext_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 27000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned OVERSAMPLE      = 16,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned PARITY          = 0,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned FIFO_DEPTH      = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    output logic                 uart_tx_pin,
    input  logic                 uart_rx_pin,
    input  logic [DATA_BITS-1:0] tx_fifo_data_in,
    input  logic                 tx_fifo_write_en,
    output logic                 tx_fifo_full,
    output logic                 tx_busy,
    output logic                 rx_fifo_empty,
    output logic [DATA_BITS-1:0] rx_fifo_data_out,
    input  logic                 rx_fifo_read_en,
    output logic                 rx_frame_error,
    output logic                 rx_parity_error,
    output logic                 rx_overrun,
    input  logic                 err_clear
);
    localparam int unsigned OS_DIV    = os_div(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned DivW      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int unsigned CntW      = $clog2(STOP_BITS * OVERSAMPLE);
    localparam bit          HasParity = (PARITY != PAR_NONE);

    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    // Oversample tick generator
    logic [DivW-1:0] div_cnt;
    logic            os_tick;

    assign os_tick = (div_cnt == DivW'(OS_DIV - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= os_tick ? '0 : div_cnt + DivW'(1);
        end
    end

    // Transmitter
    tx_state_t            tx_state;
    logic                 tx_pend;
    logic [CntW-1:0]      tx_cnt, tx_last;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift, tx_head;
    logic                 tx_par, tx_empty, tx_pop, tx_bit_end;

    always_comb begin
        tx_last    = (tx_state == TxStop) ? CntW'(STOP_BITS * OVERSAMPLE - 1)
                                          : CntW'(OVERSAMPLE - 1);
        tx_bit_end = os_tick && (tx_cnt == tx_last);
        // Popping at the end of STOP lets back-to-back frames run without an idle gap.
        tx_pop     = !tx_empty && ((tx_state == TxIdle && !tx_pend) ||
                                   (tx_state == TxStop && tx_bit_end));
    end

    assign tx_busy = (tx_state != TxIdle) || tx_pend || !tx_empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state    <= TxIdle;
            tx_pend     <= 1'b0;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            uart_tx_pin <= 1'b1;
        end else begin
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_par   <= par_bit(tx_head);
            end
            case (tx_state)
                TxIdle: begin
                    if (tx_pop) begin
                        tx_pend <= 1'b1;
                    end else if (tx_pend && os_tick) begin
                        tx_pend     <= 1'b0;
                        tx_state    <= TxStart;
                        tx_cnt      <= '0;
                        uart_tx_pin <= 1'b0;
                    end
                end
                default: begin
                    if (os_tick && !tx_bit_end) begin
                        tx_cnt <= tx_cnt + CntW'(1);
                    end else if (tx_bit_end) begin
                        tx_cnt <= '0;
                        unique case (tx_state)
                            TxStart: begin
                                tx_state    <= TxData;
                                tx_bit      <= '0;
                                uart_tx_pin <= tx_shift[0];
                            end
                            TxData: begin
                                if (tx_bit == 3'(DATA_BITS - 1)) begin
                                    tx_state    <= HasParity ? TxParity : TxStop;
                                    uart_tx_pin <= HasParity ? tx_par : 1'b1;
                                end else begin
                                    tx_bit      <= tx_bit + 3'd1;
                                    tx_shift    <= tx_shift >> 1;
                                    uart_tx_pin <= tx_shift[1];
                                end
                            end
                            TxParity: begin
                                tx_state    <= TxStop;
                                uart_tx_pin <= 1'b1;
                            end
                            TxStop: begin
                                tx_state    <= tx_pop ? TxStart : TxIdle;
                                uart_tx_pin <= !tx_pop;
                            end
                            default: tx_state <= TxIdle;
                        endcase
                    end
                end
            endcase
        end
    end

    uart_ext_fifo #(
        .DATA_WIDTH(DATA_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .write_en(tx_fifo_write_en),
        .data_in (tx_fifo_data_in),
        .read_en (tx_pop),
        .data_out(tx_head),
        .empty   (tx_empty),
        .full    (tx_fifo_full)
    );

    // Receiver
    logic [1:0]           rx_sync;
    logic                 rx_s;
    rx_state_t            rx_state;
    logic [CntW-1:0]      rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit, rx_sample, rx_done, rx_push, rx_full;

    assign rx_s      = rx_sync[1];
    assign rx_sample = os_tick && (rx_cnt == CntW'(OVERSAMPLE - 1));
    assign rx_done   = (rx_state == RxStop) && rx_sample;
    assign rx_push   = rx_done && !rx_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync    <= 2'b11;
            rx_state   <= RxIdle;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx_pin};
            case (rx_state)
                RxIdle: begin
                    if (os_tick && !rx_s) begin
                        rx_state <= RxStart;
                        rx_cnt   <= '0;
                    end
                end
                RxStart: begin
                    if (os_tick) begin
                        if (rx_cnt == CntW'(OVERSAMPLE / 2 - 1)) begin
                            // Line high at mid-start is a glitch, not a frame.
                            rx_cnt   <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s ? RxIdle : RxData;
                        end else begin
                            rx_cnt <= rx_cnt + CntW'(1);
                        end
                    end
                end
                default: begin
                    if (os_tick && !rx_sample) begin
                        rx_cnt <= rx_cnt + CntW'(1);
                    end else if (rx_sample) begin
                        rx_cnt <= '0;
                        unique case (rx_state)
                            RxData: begin
                                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                                if (rx_bit == 3'(DATA_BITS - 1)) begin
                                    rx_state <= HasParity ? RxParity : RxStop;
                                end else begin
                                    rx_bit <= rx_bit + 3'd1;
                                end
                            end
                            RxParity: begin
                                rx_par_bit <= rx_s;
                                rx_state   <= RxStop;
                            end
                            default: rx_state <= RxIdle;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_frame_error  <= 1'b0;
            rx_parity_error <= 1'b0;
            rx_overrun      <= 1'b0;
        end else begin
            if (rx_done && !rx_s) begin
                rx_frame_error <= 1'b1;
            end else if (err_clear) begin
                rx_frame_error <= 1'b0;
            end
            if (rx_done && HasParity && (par_bit(rx_shift) != rx_par_bit)) begin
                rx_parity_error <= 1'b1;
            end else if (err_clear) begin
                rx_parity_error <= 1'b0;
            end
            if (rx_done && rx_full) begin
                rx_overrun <= 1'b1;
            end else if (err_clear) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    uart_ext_fifo #(
        .DATA_WIDTH(DATA_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .write_en(rx_push),
        .data_in (rx_shift),
        .read_en (rx_fifo_read_en),
        .data_out(rx_fifo_data_out),
        .empty   (rx_fifo_empty),
        .full    (rx_full)
    );

endmodule

// File: tb/tb_uart_ext.sv
// Directed bench for uart_ext: three instances (8N1, 7E2, 8O1) at one clock per
// oversample tick, checking line waveforms, reception, errors, overrun and reset.
module tb_uart_ext;
    localparam int unsigned Clk  = 1600000;
    localparam int unsigned Baud = 100000;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic clr = 1'b0;
    always #5 clock = ~clock;

    logic       tx_a, rx_a = 1'b1, wr_a = 1'b0, full_a, busy_a, empty_a, rd_a = 1'b0;
    logic       ferr_a, perr_a, ovr_a;
    logic [7:0] din_a = '0, dout_a;
    logic       tx_b, rx_b = 1'b1, wr_b = 1'b0, full_b, busy_b, empty_b, rd_b = 1'b0;
    logic       ferr_b, perr_b, ovr_b;
    logic [6:0] din_b = '0, dout_b;
    logic       tx_c, rx_c = 1'b1, wr_c = 1'b0, full_c, busy_c, empty_c, rd_c = 1'b0;
    logic       ferr_c, perr_c, ovr_c;
    logic [7:0] din_c = '0, dout_c;

    uart_ext #(.CLOCK_FREQUENCY(Clk), .BAUD_RATE(Baud), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clock(clock), .reset_n(reset_n), .uart_tx_pin(tx_a), .uart_rx_pin(rx_a),
        .tx_fifo_data_in(din_a), .tx_fifo_write_en(wr_a), .tx_fifo_full(full_a),
        .tx_busy(busy_a), .rx_fifo_empty(empty_a), .rx_fifo_data_out(dout_a),
        .rx_fifo_read_en(rd_a), .rx_frame_error(ferr_a), .rx_parity_error(perr_a),
        .rx_overrun(ovr_a), .err_clear(clr));

    uart_ext #(.CLOCK_FREQUENCY(Clk), .BAUD_RATE(Baud), .OVERSAMPLE(16), .DATA_BITS(7),
               .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clock(clock), .reset_n(reset_n), .uart_tx_pin(tx_b), .uart_rx_pin(rx_b),
        .tx_fifo_data_in(din_b), .tx_fifo_write_en(wr_b), .tx_fifo_full(full_b),
        .tx_busy(busy_b), .rx_fifo_empty(empty_b), .rx_fifo_data_out(dout_b),
        .rx_fifo_read_en(rd_b), .rx_frame_error(ferr_b), .rx_parity_error(perr_b),
        .rx_overrun(ovr_b), .err_clear(clr));

    uart_ext #(.CLOCK_FREQUENCY(Clk), .BAUD_RATE(Baud), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clock(clock), .reset_n(reset_n), .uart_tx_pin(tx_c), .uart_rx_pin(rx_c),
        .tx_fifo_data_in(din_c), .tx_fifo_write_en(wr_c), .tx_fifo_full(full_c),
        .tx_busy(busy_c), .rx_fifo_empty(empty_c), .rx_fifo_data_out(dout_c),
        .rx_fifo_read_en(rd_c), .rx_frame_error(ferr_c), .rx_parity_error(perr_c),
        .rx_overrun(ovr_c), .err_clear(clr));

    int n_total = 0;
    int n_bad = 0;
    logic [7:0] exp5 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic pin_of(input int inst);
        return (inst == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic busy_of(input int inst);
        return (inst == 0) ? busy_a : busy_b;
    endfunction

    task automatic push(input int inst, input logic [7:0] d);
        if (inst == 0) begin
            din_a = d;
            wr_a  = 1'b1;
        end else begin
            din_b = d[6:0];
            wr_b  = 1'b1;
        end
        @(negedge clock);
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    task automatic pop(input int inst);
        if (inst == 0) rd_a = 1'b1;
        else rd_c = 1'b1;
        @(negedge clock);
        rd_a = 1'b0;
        rd_c = 1'b0;
    endtask

    // bits[i] is the i-th level on the line; each must hold exactly 16 clocks.
    task automatic expect_tx(input string tag, input int inst, input logic [15:0] bits,
                             input int nbits);
        int waited = 0;
        while (pin_of(inst) !== 1'b0 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "_start_seen"}, 32'(waited < 100), 32'd1);
        if (waited >= 100) return;
        for (int k = 0; k < nbits * 16; k++) begin
            if (k % 16 == 0 || k % 16 == 15)
                check($sformatf("%s_bit%0d_off%0d", tag, k / 16, k % 16),
                      32'(pin_of(inst)), 32'(bits[k / 16]));
            if (k == nbits * 16 - 1) check({tag, "_busy_last"}, 32'(busy_of(inst)), 32'd1);
            @(negedge clock);
        end
        check({tag, "_idle_pin"}, 32'(pin_of(inst)), 32'd1);
        check({tag, "_busy_end"}, 32'(busy_of(inst)), 32'd0);
    endtask

    task automatic send_rx(input int inst, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (inst == 0) rx_a = bits[i];
            else rx_c = bits[i];
            repeat (16) @(negedge clock);
        end
        rx_a = 1'b1;
        rx_c = 1'b1;
    endtask

    initial begin
        int waited;
        repeat (3) @(negedge clock);
        check("rst_pin", {tx_a, tx_b, tx_c}, 3'b111);
        check("rst_busy", {busy_a, busy_b, busy_c}, 0);
        check("rst_full", {full_a, full_b, full_c}, 0);
        check("rst_empty", {empty_a, empty_b, empty_c}, 3'b111);
        check("rst_dout", {dout_a, dout_b, dout_c}, 0);
        check("rst_err", {ferr_a, perr_a, ovr_a, ferr_b, perr_b, ovr_b, ferr_c, perr_c, ovr_c}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        push(0, 8'hA5);
        expect_tx("t1_8n1", 0, 16'h034A, 10);

        // 7E2 0x55: 0,1010101,0,1,1
        push(1, 8'h55);
        expect_tx("t2_7e2", 1, 16'h06AA, 11);

        // 8O1 0x3C with parity 1, then with parity flipped
        send_rx(2, 16'h0678, 11);
        repeat (4) @(negedge clock);
        check("t3_empty", empty_c, 0);
        check("t3_data", dout_c, 8'h3C);
        check("t3_perr", perr_c, 0);
        check("t3_ferr", ferr_c, 0);
        pop(2);
        check("t3_empty_after_pop", empty_c, 1);
        send_rx(2, 16'h0478, 11);
        repeat (4) @(negedge clock);
        check("t3b_perr", perr_c, 1);
        check("t3b_data", dout_c, 8'h3C);
        check("t3b_ferr", ferr_c, 0);
        pop(2);

        // Glitch, then 0x96 with a low stop bit
        rx_a = 1'b0;
        repeat (5) @(negedge clock);
        rx_a = 1'b1;
        repeat (40) @(negedge clock);
        check("t4_glitch_empty", empty_a, 1);
        check("t4_glitch_err", {ferr_a, perr_a, ovr_a}, 0);
        send_rx(0, 16'h012C, 10);
        repeat (24) @(negedge clock);
        check("t4_ferr", ferr_a, 1);
        check("t4_empty", empty_a, 0);
        check("t4_data", dout_a, 8'h96);
        pop(0);
        check("t4_single_write", empty_a, 1);
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
        check("t4_ferr_cleared", ferr_a, 0);

        // FIFO_DEPTH+1 frames without popping
        for (int i = 0; i < 5; i++) begin
            send_rx(0, {5'b0, 1'b1, exp5[i], 1'b0}, 10);
            if (i == 3) check("t5_no_ovr_yet", ovr_a, 0);
        end
        repeat (4) @(negedge clock);
        check("t5_ovr", ovr_a, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_data%0d", i), dout_a, exp5[i]);
            pop(0);
        end
        check("t5_empty", empty_a, 1);

        // Reset in the middle of a low data bit
        push(0, 8'h00);
        waited = 0;
        while (tx_a !== 1'b0 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("t6_start_seen", 32'(waited < 100), 32'd1);
        repeat (24) @(negedge clock);
        check("t6_mid_bit_low", tx_a, 0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_pin", tx_a, 1);
        check("t6_async_busy", busy_a, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("t6_busy_after", busy_a, 0);
        check("t6_pin_after", tx_a, 1);
        push(0, 8'hA5);
        expect_tx("t6_retx", 0, 16'h034A, 10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
